// File: rtl/insertion_sort.sv
// ---------------------------------------------------------------------------
// insertion_sort
//   Sequential insertion sort of NUM_VALS unsigned elements, SIZE_DATA bits
//   each. The sort does one compare per clock. o_done rises after
//   2*(NUM_VALS-1) + (number of inversions in the input) edges.
//
// Ports
//   i_clk    rising-edge clock for all state
//   i_rst    asynchronous active-high reset
//   i_start  start request, accepted in IDLE or DONE
//   i_data   packed unsorted input, element k at [k*SIZE_DATA +: SIZE_DATA]
//   o_done   high while o_data holds a completed sorted result
//   o_data   registered sorted output, ascending, element 0 is the smallest
// ---------------------------------------------------------------------------
module insertion_sort #(
  parameter int NUM_VALS  = 8,
  parameter int SIZE_DATA = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [NUM_VALS*SIZE_DATA-1:0] i_data,
  output logic                          o_done,
  output logic [NUM_VALS*SIZE_DATA-1:0] o_data
);

  localparam int IW = $clog2(NUM_VALS);
  // One extra bit so the inner index can hold -1.
  localparam int JW = IW + 1;

  typedef enum logic [1:0] {IDLE, PICK, CMP, DONE} state_t;

  state_t                state_reg;
  logic [SIZE_DATA-1:0]  arr_reg [NUM_VALS];
  logic [SIZE_DATA-1:0]  key_reg;
  logic [IW-1:0]         i_reg;
  logic signed [JW-1:0]  j_reg;

  logic [IW-1:0]         j_idx;
  logic [IW-1:0]         jp1_idx;
  logic [SIZE_DATA-1:0]  arr_j;
  logic                  shift;
  logic                  last_i;

  assign j_idx   = j_reg[IW-1:0];
  assign jp1_idx = IW'(j_reg + JW'(1));
  // arr_j is meaningless when j = -1; the sign-bit guard masks it.
  assign arr_j   = arr_reg[j_idx];
  // Strict compare keeps equal elements in their original order.
  assign shift   = !j_reg[JW-1] && (arr_j > key_reg);
  assign last_i  = (i_reg == IW'(NUM_VALS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      o_done    <= 1'b0;
      o_data    <= '0;
      key_reg   <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      for (int k = 0; k < NUM_VALS; k++) begin
        arr_reg[k] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // DONE holds o_done/o_data until a new start, which then behaves
          // exactly like a start from IDLE.
          if (i_start) begin
            for (int k = 0; k < NUM_VALS; k++) begin
              arr_reg[k] <= i_data[k*SIZE_DATA +: SIZE_DATA];
            end
            i_reg     <= IW'(1);
            o_done    <= 1'b0;
            state_reg <= PICK;
          end
        end

        PICK: begin
          key_reg   <= arr_reg[i_reg];
          j_reg     <= {1'b0, i_reg} - JW'(1);
          state_reg <= CMP;
        end

        CMP: begin
          if (shift) begin
            arr_reg[jp1_idx] <= arr_j;
            j_reg            <= j_reg - JW'(1);
          end else begin
            arr_reg[jp1_idx] <= key_reg;
            if (last_i) begin
              // The key write above lands on this same edge, so the output
              // is assembled from the array with the key already in place.
              for (int k = 0; k < NUM_VALS; k++) begin
                o_data[k*SIZE_DATA +: SIZE_DATA] <=
                  (jp1_idx == IW'(k)) ? key_reg : arr_reg[k];
              end
              o_done    <= 1'b1;
              state_reg <= DONE;
            end else begin
              i_reg     <= i_reg + IW'(1);
              state_reg <= PICK;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insertion_sort.sv
module tb_insertion_sort;

  localparam int N = 8;
  localparam int W = 8;
  localparam int DW = N * W;

  logic          i_clk;
  logic          i_rst;
  logic          i_start;
  logic [DW-1:0] i_data;
  logic          o_done;
  logic [DW-1:0] o_data;

  int checks;
  int failures;
  logic [DW-1:0] prev_out;

  insertion_sort #(.NUM_VALS(N), .SIZE_DATA(W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_data  (i_data),
    .o_done  (o_done),
    .o_data  (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: sorted output by repeated minimum extraction, latency from
  // the inversion count of the input.
  task automatic model(input logic [DW-1:0] din, output logic [DW-1:0] dout,
                       output int lat);
    int v[N];
    bit used[N];
    int inv;
    for (int k = 0; k < N; k++) begin
      v[k] = int'(din[k*W +: W]);
      used[k] = 1'b0;
    end
    inv = 0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++)
        if (v[a] > v[b]) inv++;
    dout = '0;
    for (int k = 0; k < N; k++) begin
      int best;
      best = -1;
      for (int m = 0; m < N; m++)
        if (!used[m] && (best < 0 || v[m] < v[best])) best = m;
      used[best] = 1'b1;
      dout[k*W +: W] = W'(v[best]);
    end
    lat = 2 * (N - 1) + inv;
  endtask

  // Called just after a rising edge. Start is sampled on the next edge.
  task automatic run_sort(input string name, input logic [DW-1:0] din,
                          input bit mid_start);
    logic [DW-1:0] exp_out;
    int exp_lat;
    int cnt;
    bit seen;
    model(din, exp_out, exp_lat);
    i_data  = din;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_data  = {$urandom, $urandom};
    check({name, "_done_drop"}, 64'(o_done), 64'd0);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      if (mid_start && cnt == 4) i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      cnt++;
      if (o_done) seen = 1'b1;
      else check({name, "_hold"}, 64'(o_data), 64'(prev_out));
    end
    check({name, "_latency"}, 64'(cnt), 64'(exp_lat));
    check({name, "_data"}, 64'(o_data), 64'(exp_out));
    $display("sort %s in=%h out=%h edges=%0d expected_edges=%0d",
             name, din, o_data, cnt, exp_lat);
    prev_out = exp_out;
  endtask

  function automatic logic [DW-1:0] pack8(input int e0, e1, e2, e3, e4, e5, e6, e7);
    return {W'(e7), W'(e6), W'(e5), W'(e4), W'(e3), W'(e2), W'(e1), W'(e0)};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    prev_out = '0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_data   = '0;
    #12;
    check("reset_done", 64'(o_done), 64'd0);
    check("reset_data", 64'(o_data), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    run_sort("mixed", pack8(1, 29, 15, 3, 20, 1, 5, 12), 1'b0);
    run_sort("sorted", pack8(0, 1, 2, 3, 4, 5, 6, 7), 1'b0);
    run_sort("descend", pack8(255, 200, 150, 100, 50, 10, 5, 0), 1'b0);
    run_sort("equal", {N{8'hAA}}, 1'b0);

    // DONE holds its result while idle.
    repeat (3) @(posedge i_clk);
    #1;
    check("done_hold_flag", 64'(o_done), 64'd1);
    check("done_hold_data", 64'(o_data), 64'(prev_out));

    // Start pulse during the sort must be ignored; restart straight from DONE.
    run_sort("ignore_start", pack8(9, 8, 7, 6, 5, 4, 3, 2), 1'b1);
    run_sort("back2back", pack8(3, 3, 1, 200, 0, 7, 7, 2), 1'b0);

    // Mid-sort asynchronous reset.
    i_data  = pack8(50, 40, 30, 20, 10, 0, 60, 70);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    check("midrst_done", 64'(o_done), 64'd0);
    check("midrst_data", 64'(o_data), 64'd0);
    $display("reset mid-sort done=%0d data=%h", o_done, o_data);
    prev_out = '0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    // No start yet: the block must stay idle.
    repeat (3) @(posedge i_clk);
    #1;
    check("postrst_idle", 64'(o_done), 64'd0);
    run_sort("after_reset", pack8(17, 4, 99, 4, 250, 0, 33, 18), 1'b0);

    for (int t = 0; t < 20; t++) begin
      logic [DW-1:0] d;
      for (int k = 0; k < N; k++)
        d[k*W +: W] = (t % 3 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      run_sort($sformatf("rand%0d", t), d, t % 4 == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
